// File: rtl/aer_rr_arbiter.sv
// aer_rr_arbiter: round-robin spike arbiter emitting events over a 4-phase req/ack AER link
module aer_rr_arbiter #(
  parameter int N_NEURONS = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic                 aer_ack,
  output logic                 aer_req,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [N_NEURONS-1:0] pending,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_cnt
);
  localparam int SW = DROP_W + ADDR_W + 1;
  localparam logic [SW-1:0] DROP_MAX = SW'((64'd1 << DROP_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, REQ, ACK_WAIT} state_t;
  state_t state;
  logic [ADDR_W-1:0] rr_ptr, sel;
  logic [N_NEURONS-1:0] clr, drops;
  logic [SW-1:0] drop_sum;
  assign clr = (state == REQ && aer_ack) ? N_NEURONS'(1) << aer_addr : '0;
  assign drops = spikes_in & pending & ~clr;
  assign drop_sum = SW'(drop_cnt) + SW'($countones(drops));
  assign busy = state != IDLE;
  always_comb begin
    sel = rr_ptr;
    for (int k = N_NEURONS - 1; k >= 0; k--)
      if (pending[rr_ptr + ADDR_W'(k)]) sel = rr_ptr + ADDR_W'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      aer_req  <= 1'b0;
      aer_addr <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr) | spikes_in;
      drop_cnt <= drop_sum > DROP_MAX ? DROP_MAX[DROP_W-1:0] : drop_sum[DROP_W-1:0];
      case (state)
        IDLE: if (|pending && !aer_ack) begin
          aer_addr <= sel;
          aer_req  <= 1'b1;
          state    <= REQ;
        end
        REQ: if (aer_ack) begin
          aer_req <= 1'b0;
          rr_ptr  <= aer_addr + ADDR_W'(1);
          state   <= ACK_WAIT;
        end
        ACK_WAIT: if (!aer_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aer_rr_arbiter.sv
// tb_aer_rr_arbiter: directed and random checks of aer_rr_arbiter against a behavioural model
module tb_aer_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] spikes_in = '0;
  logic aer_ack = 1'b0;
  logic aer_req;
  logic [3:0] aer_addr;
  logic [15:0] pending;
  logic busy;
  logic [7:0] drop_cnt;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] m_pend = '0;
  int m_ptr = 0;
  int m_phase = 0;
  int m_addr = 0;
  int m_drop = 0;
  bit m_req = 0;
  bit prev_req = 0;
  int got_q[$];
  aer_rr_arbiter dut (
    .clk(clk), .rst(rst), .spikes_in(spikes_in), .aer_ack(aer_ack),
    .aer_req(aer_req), .aer_addr(aer_addr), .pending(pending),
    .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model(input logic [15:0] s, input bit a, input bit r);
    int c;
    logic [15:0] old;
    if (r) begin
      m_pend = '0; m_ptr = 0; m_phase = 0; m_addr = 0; m_drop = 0; m_req = 0;
      return;
    end
    old = m_pend;
    c = (m_phase == 1 && a) ? m_addr : -1;
    for (int i = 0; i < 16; i++) begin
      if (s[i] && old[i] && i != c) m_drop++;
      m_pend[i] = (old[i] && i != c) || s[i];
    end
    if (m_drop > 255) m_drop = 255;
    if (m_phase == 0) begin
      if (old != 0 && !a) begin
        for (int k = 15; k >= 0; k--) if (old[(m_ptr + k) % 16]) m_addr = (m_ptr + k) % 16;
        m_req = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (a) begin m_req = 0; m_ptr = (m_addr + 1) % 16; m_phase = 2; end
    end else if (!a) m_phase = 0;
  endtask
  task automatic step(input logic [15:0] s, input bit a, input bit r);
    @(negedge clk);
    spikes_in = s; aer_ack = a; rst = r;
    @(posedge clk);
    model(s, a, r);
    #1;
    chk("req", aer_req, m_req);
    chk("pending", pending, m_pend);
    chk("busy", busy, m_phase != 0);
    chk("drop_cnt", drop_cnt, m_drop);
    if (m_req) chk("addr", aer_addr, m_addr);
    if (r) chk("addr_rst", aer_addr, 0);
    if (aer_req && !prev_req) got_q.push_back(int'(aer_addr));
    prev_req = aer_req;
  endtask
  task automatic respond(input int n);
    repeat (n) step('0, aer_req, 0);
  endtask
  task automatic do_reset();
    step(16'hFFFF, 0, 1);
    step(16'hFFFF, 0, 1);
    got_q.delete();
  endtask
  task automatic chk_order(input string tag, input int exp[$]);
    chk({tag, "_n"}, got_q.size(), exp.size());
    foreach (exp[i]) if (i < got_q.size()) chk(tag, got_q[i], exp[i]);
    got_q.delete();
  endtask
  initial begin
    do_reset();
    step('0, 0, 0);
    chk("rst_pend", pending, 0);
    // single event with slow receiver
    step(16'h0020, 0, 0);
    chk("lat1_req", aer_req, 0);
    step('0, 0, 0);
    chk("lat2_req", aer_req, 1);
    chk("lat2_addr", aer_addr, 5);
    step('0, 0, 0);
    step('0, 1, 0);
    chk("ack_pend", pending, 0);
    step('0, 0, 0);
    chk("idle", busy, 0);
    // round-robin order
    do_reset();
    step(16'h8421, 0, 0);
    respond(16);
    chk_order("rr", '{0, 5, 10, 15});
    step(16'h0003, 0, 0);
    respond(10);
    chk_order("wrap", '{0, 1});
    // fairness after serving 3
    do_reset();
    step(16'h0008, 0, 0);
    respond(6);
    step(16'h0009, 0, 0);
    respond(10);
    chk_order("fair", '{3, 0, 3});
    // collisions while req held
    do_reset();
    step(16'h0080, 0, 0);
    step('0, 0, 0);
    step(16'h0080, 0, 0);
    step('0, 0, 0);
    step(16'h0080, 0, 0);
    chk("coll_drop", drop_cnt, 2);
    chk("coll_pend7", pending[7], 1);
    repeat (20) step(16'hFFFF, 0, 0);
    chk("sat", drop_cnt, 255);
    // stale ack in idle
    do_reset();
    step(16'h0004, 1, 0);
    repeat (3) step('0, 1, 0);
    chk("stale_req", aer_req, 0);
    step('0, 0, 0);
    step('0, 0, 0);
    chk("stale_go", aer_req, 1);
    // spike on granted bit during ack cycle
    step(16'h0004, 1, 0);
    chk("reack_pend", pending[2], 1);
    chk("reack_drop", drop_cnt, 0);
    got_q.delete();
    respond(8);
    chk_order("reserve", '{2});
    // reset during REQ
    step(16'h0010, 0, 0);
    step('0, 0, 0);
    chk("req_up", aer_req, 1);
    step('0, 0, 1);
    chk("rst_req", aer_req, 0);
    // randomized traffic
    begin
      bit mode = 0;
      for (int c = 0; c < 3000; c++) begin
        logic [15:0] s;
        if (c % 300 == 0) mode = bit'($urandom_range(0, 1));
        s = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
        step(s, mode ? aer_req : bit'($urandom_range(0, 1)), $urandom_range(0, 399) == 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
